// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RV32I pipeline: issues loads/stores on a req/ready bus,
// stalls upstream while an access is outstanding, and registers the EX/MEM-to-WB fields.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_jal,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_pc_plus4,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rd_m,
    output logic        regwrite_m,
    output logic        memtoreg_m,
    output logic        jal_m,
    output logic [31:0] pc_plus4_m,
    output logic [31:0] alu_result_m,
    output logic [31:0] read_data_m,
    output logic        mem_fault
);
    typedef enum logic {IDLE, BUSY} state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic        jal;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } wb_t;

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    wb_t           cap_q, cap_d;
    wb_t           out_q, out_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          fault_q, fault_d;

    logic        mem_op, f3_ok, misaligned, fault, timeout_hit;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    wb_t         ex_wb;

    // Access legality and store-lane formatting, decoded straight from EX.
    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        mem_op     = ex_valid & (ex_memread | ex_memwrite);
        f3_ok      = ex_memwrite ? (ex_funct3 inside {3'b000, 3'b001, 3'b010})
                                 : (ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((ex_funct3[1:0] == 2'b01) & ex_alu_result[0])
                   | ((ex_funct3[1:0] == 2'b10) & (|ex_alu_result[1:0]));
        fault      = mem_op & (~f3_ok | misaligned);

        st_wdata = ex_store_data;
        st_wstrb = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_store_data[7:0]}};
                st_wstrb = 4'b0001 << ex_alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_store_data[15:0]}};
                st_wstrb = 4'b0011 << ex_alu_result[1:0];
            end
            default: ;
        endcase
        if (!ex_memwrite) begin
            st_wdata = '0;
            st_wstrb = '0;
        end
    end

    always_comb begin
        case (cap_q.alu_result[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = cap_q.alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Abort fires in the BUSY cycle in which the wait count reaches TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == BUSY) && !dmem_ready && (TIMEOUT_CYCLES != 0)
                      && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        ex_wb = '{rd: ex_rd, regwrite: ex_regwrite, memtoreg: ex_memtoreg, jal: ex_jal,
                  pc_plus4: ex_pc_plus4, alu_result: ex_alu_result, read_data: 32'd0};
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        out_d    = out_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        funct3_d = funct3_q;
        fault_d  = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                out_d = ex_wb;
                if (!ex_valid) begin
                    out_d.rd       = '0;
                    out_d.regwrite = 1'b0;
                end else if (fault) begin
                    out_d.regwrite = 1'b0;
                    fault_d        = 1'b1;
                end else if (mem_op) begin
                    stall    = 1'b1;
                    state_d  = BUSY;
                    cap_d    = ex_wb;
                    we_d     = ex_memwrite;
                    wdata_d  = st_wdata;
                    wstrb_d  = st_wstrb;
                    funct3_d = ex_funct3;
                    out_d    = '0;
                end
            end
            BUSY: begin
                stall = ~dmem_ready & ~timeout_hit;
                if (dmem_ready) begin
                    out_d           = cap_q;
                    out_d.read_data = we_q ? 32'd0 : ld_data;
                    state_d         = IDLE;
                    cnt_d           = '0;
                end else if (timeout_hit) begin
                    out_d          = cap_q;
                    out_d.regwrite = 1'b0;
                    fault_d        = 1'b1;
                    state_d        = IDLE;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cap_q    <= '0;
            out_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            funct3_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            out_q    <= out_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            funct3_q <= funct3_d;
            fault_q  <= fault_d;
        end
    end

    assign dmem_req   = (state_q == BUSY);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = dmem_req ? {cap_q.alu_result[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = dmem_req ? wdata_q : 32'd0;
    assign dmem_wstrb = dmem_req ? wstrb_q : 4'd0;

    assign rd_m         = out_q.rd;
    assign regwrite_m   = out_q.regwrite;
    assign memtoreg_m   = out_q.memtoreg;
    assign jal_m        = out_q.jal;
    assign pc_plus4_m   = out_q.pc_plus4;
    assign alu_result_m = out_q.alu_result;
    assign read_data_m  = out_q.read_data;
    assign mem_fault    = fault_q;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized back-to-back
// traffic checked against a transaction-level reference model.
module tb_memory_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_regwrite = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0;
    logic        ex_memtoreg = 1'b0, ex_jal = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_alu_result = '0, ex_store_data = '0, ex_pc_plus4 = '0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [4:0]  rd_m;
    logic        regwrite_m, memtoreg_m, jal_m, mem_fault;
    logic [31:0] pc_plus4_m, alu_result_m, read_data_m;

    int checks = 0;
    int errors = 0;

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_jal(ex_jal), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_pc_plus4(ex_pc_plus4),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .rd_m(rd_m), .regwrite_m(regwrite_m),
        .memtoreg_m(memtoreg_m), .jal_m(jal_m), .pc_plus4_m(pc_plus4_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        valid;
        bit [4:0]  rd;
        bit        regwrite, memread, memwrite, memtoreg, jal;
        bit [2:0]  f3;
        bit [31:0] alu, sdata, pc4;
    } instr_t;

    typedef struct {
        bit [4:0]  rd;
        bit        regwrite, memtoreg, jal, fault, access, we;
        bit [31:0] pc4, alu, rdata, addr, wdata;
        bit [3:0]  wstrb;
        int        busy, stall;
    } exp_t;

    // Reference model: wait_n is the number of BUSY cycles before ready; negative = never ready.
    function automatic exp_t model(input instr_t i, input bit [31:0] word, input int wait_n);
        exp_t    e;
        int      size, lane;
        bit      legal;
        bit [63:0] v, span;
        e = '{default: 0};
        e.rd       = i.valid ? i.rd : 5'd0;
        e.regwrite = i.valid && i.regwrite;
        e.memtoreg = i.memtoreg;
        e.jal      = i.jal;
        e.pc4      = i.pc4;
        e.alu      = i.alu;
        if (!(i.valid && (i.memread || i.memwrite))) return e;
        size  = 1 << (i.f3 % 4);
        lane  = int'(i.alu % 4);
        legal = i.memwrite ? (i.f3 <= 2) : (i.f3 <= 2 || i.f3 == 4 || i.f3 == 5);
        if (!legal || (i.alu % size) != 0) begin
            e.regwrite = 1'b0;
            e.fault    = 1'b1;
            return e;
        end
        e.access = 1'b1;
        e.we     = i.memwrite;
        e.addr   = i.alu & ~32'd3;
        if (i.memwrite) begin
            if (size == 1)      e.wdata = (i.sdata % 256) * 32'h0101_0101;
            else if (size == 2) e.wdata = (i.sdata % 65536) * 32'h0001_0001;
            else                e.wdata = i.sdata;
            e.wstrb = 4'(((1 << size) - 1) << lane);
        end
        if (wait_n < 0) begin
            e.busy     = TO;
            e.stall    = TO;
            e.regwrite = 1'b0;
            e.fault    = 1'b1;
            return e;
        end
        e.busy  = wait_n + 1;
        e.stall = wait_n + 1;
        if (!i.memwrite) begin
            span = 64'd1 << (8 * size);
            v = (64'(word) >> (8 * lane)) % span;
            if (i.f3 < 4 && size < 4 && v >= span / 2) v = v - span;
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    task automatic drive(input instr_t i);
        ex_valid      = i.valid;
        ex_rd         = i.rd;
        ex_regwrite   = i.regwrite;
        ex_memread    = i.memread;
        ex_memwrite   = i.memwrite;
        ex_memtoreg   = i.memtoreg;
        ex_jal        = i.jal;
        ex_funct3     = i.f3;
        ex_alu_result = i.alu;
        ex_store_data = i.sdata;
        ex_pc_plus4   = i.pc4;
    endtask

    // Called at a negedge; returns at the negedge after the instruction was consumed and checked.
    task automatic run_op(input string name, input instr_t i, input bit [31:0] word, input int wait_n);
        exp_t e;
        int   busy_n, stall_n;
        bit   st, done;
        e = model(i, word, wait_n);
        drive(i);
        busy_n = 0;
        stall_n = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (dmem_req) begin
                checks++;
                if ({dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== {e.we, e.addr, e.wdata, e.wstrb}) begin
                    errors++;
                    $display("FAIL %s bus we/addr/wdata/wstrb got %b/%h/%h/%b exp %b/%h/%h/%b", name,
                             dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, e.we, e.addr, e.wdata, e.wstrb);
                end
                busy_n++;
                dmem_ready = (wait_n >= 0) && (busy_n > wait_n);
                dmem_rdata = dmem_ready ? word : $urandom;
            end else begin
                dmem_ready = 1'($urandom);
                dmem_rdata = $urandom;
            end
            #1;
            st = stall;
            stall_n += int'(st);
            @(posedge clk);
            if (!st) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s consume got stalled-forever exp consumed", name);
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        checks++;
        if (busy_n != e.busy) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_n, e.busy);
        end
        checks++;
        if (stall_n != e.stall) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d exp %0d", name, stall_n, e.stall);
        end
        checks++;
        if ({rd_m, regwrite_m, memtoreg_m, jal_m} !== {e.rd, e.regwrite, e.memtoreg, e.jal}) begin
            errors++;
            $display("FAIL %s rd/regwrite/memtoreg/jal got %0d/%b/%b/%b exp %0d/%b/%b/%b", name,
                     rd_m, regwrite_m, memtoreg_m, jal_m, e.rd, e.regwrite, e.memtoreg, e.jal);
        end
        checks++;
        if ({pc_plus4_m, alu_result_m} !== {e.pc4, e.alu}) begin
            errors++;
            $display("FAIL %s pc4/alu got %h/%h exp %h/%h", name, pc_plus4_m, alu_result_m, e.pc4, e.alu);
        end
        checks++;
        if (read_data_m !== e.rdata) begin
            errors++;
            $display("FAIL %s read_data got %h exp %h", name, read_data_m, e.rdata);
        end
        checks++;
        if (mem_fault !== e.fault) begin
            errors++;
            $display("FAIL %s mem_fault got %b exp %b", name, mem_fault, e.fault);
        end
    endtask

    function automatic instr_t mk(input bit rd_w, input bit ld, input bit st, input bit [2:0] f3,
                                  input bit [31:0] addr, input bit [31:0] sdata);
        instr_t i;
        i = '{default: 0};
        i.valid = 1'b1;
        i.rd = 5'd9;
        i.regwrite = rd_w;
        i.memread = ld;
        i.memwrite = st;
        i.memtoreg = ld;
        i.f3 = f3;
        i.alu = addr;
        i.sdata = sdata;
        i.pc4 = 32'h0000_4004;
        return i;
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_m, regwrite_m, memtoreg_m, jal_m, pc_plus4_m, alu_result_m, read_data_m} !== '0) begin
            errors++;
            $display("FAIL reset wb_outputs got nonzero exp all zero");
        end
        checks++;
        if ({dmem_req, stall, mem_fault} !== 3'b000) begin
            errors++;
            $display("FAIL reset req/stall/fault got %b exp 000", {dmem_req, stall, mem_fault});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        instr_t i;
        i = mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0);
        i.rd = 5'd5;
        run_op("alu_add", i, 32'h0, 0);
        checks++;
        if ({rd_m, regwrite_m, alu_result_m} !== {5'd5, 1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL alu_add literal got %0d/%b/%h exp 5/1/00001234", rd_m, regwrite_m, alu_result_m);
        end
    endtask

    task automatic test_load_byte();
        run_op("lb_lane3", mk(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0), 32'h80FF_0000, 0);
        checks++;
        if ({read_data_m, memtoreg_m} !== {32'hFFFF_FF80, 1'b1}) begin
            errors++;
            $display("FAIL lb_lane3 literal got %h/%b exp ffffff80/1", read_data_m, memtoreg_m);
        end
    endtask

    task automatic test_store_half();
        run_op("sh_hi", mk(1'b0, 1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD), 32'h0, 1);
        run_op("sb_lane1", mk(1'b0, 1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_005A), 32'h0, 0);
        run_op("sw", mk(1'b0, 1'b0, 1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF), 32'h0, 0);
    endtask

    task automatic test_faults();
        run_op("lw_misaligned", mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0), 32'h0, 0);
        run_op("after_fault", mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0), 32'h0, 0);
        run_op("lh_odd", mk(1'b1, 1'b1, 1'b0, 3'b001, 32'h203, 32'h0), 32'h0, 0);
        run_op("ld_f3_011", mk(1'b1, 1'b1, 1'b0, 3'b011, 32'h200, 32'h0), 32'h0, 0);
        run_op("st_f3_100", mk(1'b0, 1'b0, 1'b1, 3'b100, 32'h200, 32'h0), 32'h0, 0);
    endtask

    task automatic test_lhu_wait();
        run_op("lhu_wait2", mk(1'b1, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0), 32'h0000_8001, 2);
        checks++;
        if (read_data_m !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu_wait2 literal got %h exp 00008001", read_data_m);
        end
    endtask

    task automatic test_timeout();
        run_op("timeout", mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0), 32'h0, -1);
        run_op("wait_max_1", mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h84, 32'h0), 32'h1357_2468, TO - 1);
        run_op("wait_max_2", mk(1'b0, 1'b0, 1'b1, 3'b010, 32'h88, 32'h2468_1357), 32'h0, TO - 1);
    endtask

    task automatic test_reset_mid_busy();
        drive(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0));
        dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy pre_req got %b exp 1", dmem_req);
        end
        rst = 1'b1;
        ex_valid = 1'b0;
        #1;
        checks++;
        if ({dmem_req, stall, mem_fault, regwrite_m, read_data_m} !== '0) begin
            errors++;
            $display("FAIL rst_mid_busy async got req=%b stall=%b rdata=%h exp all zero", dmem_req, stall, read_data_m);
        end
        @(negedge clk);
        rst = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        dmem_ready = 1'b0;
        checks++;
        if ({dmem_req, mem_fault, regwrite_m, read_data_m} !== '0) begin
            errors++;
            $display("FAIL rst_mid_busy discard got req=%b fault=%b rw=%b rdata=%h exp zero",
                     dmem_req, mem_fault, regwrite_m, read_data_m);
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        bit [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        i = '{default: 0};
        i.valid = 1'b1;
        i.rd = 5'($urandom);
        i.regwrite = 1'($urandom);
        i.memtoreg = 1'($urandom);
        i.jal = 1'($urandom);
        i.alu = $urandom;
        i.sdata = $urandom;
        i.pc4 = $urandom;
        case ($urandom_range(0, 4))
            0: begin i.valid = 1'b0; i.memread = 1'($urandom); end
            1: ;
            2: begin i.memread = 1'b1; i.f3 = lf[$urandom_range(0, 4)]; end
            3: begin i.memwrite = 1'b1; i.f3 = 3'($urandom_range(0, 2)); end
            default: begin
                if ($urandom_range(0, 1) == 1) i.memread = 1'b1;
                else i.memwrite = 1'b1;
                i.f3 = 3'($urandom);
            end
        endcase
        if (i.memread || i.memwrite) begin
            if ($urandom_range(0, 4) != 0) i.alu = i.alu & ~((32'd1 << i.f3[1:0]) - 32'd1);
        end
        return i;
    endfunction

    task automatic test_back_to_back();
        for (int n = 0; n < 80; n++) begin
            run_op($sformatf("rand%0d", n), rand_instr(), $urandom, $urandom_range(0, TO - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_faults();
        test_lhu_wait();
        test_timeout();
        test_reset_mid_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, between the execute stage and the writeback stage.
- Takes EX/MEM control and data, performs loads and stores over a req/ready data-memory bus, and stalls upstream while an access is outstanding.
- Sign/zero-extends load data, then registers everything the writeback stage consumes: destination register, RegWrite, MemtoReg, JAL, PC+4, ALU result, read data.

Parameters:
- TIMEOUT_CYCLES, 16, max BUSY cycles waiting on dmem_ready before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- ex_valid  input  1  EX holds a valid instruction
- ex_rd  input  5  destination register
- ex_regwrite  input  1  register write enable
- ex_memread  input  1  load
- ex_memwrite  input  1  store
- ex_memtoreg  input  1  WB selects read data
- ex_jal  input  1  WB selects PC+4
- ex_funct3  input  3  access size/sign
- ex_alu_result  input  32  ALU result / byte address
- ex_store_data  input  32  rs2 data for stores
- ex_pc_plus4  input  32  PC+4
- stall  output  1  hold EX/ID/IF this cycle
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word address, bits [1:0] = 0
- dmem_wdata  output  32  lane-replicated store data
- dmem_wstrb  output  4  byte enables
- dmem_ready  input  1  request accepted/complete this cycle
- dmem_rdata  input  32  read word, valid with dmem_ready
- rd_m  output  5  to WB RDM
- regwrite_m  output  1  to WB RegWriteEnM
- memtoreg_m  output  1  to WB MemtoRegM
- jal_m  output  1  to WB JALM
- pc_plus4_m  output  32  to WB PCPlus4W
- alu_result_m  output  32  to WB ALU_ResultW
- read_data_m  output  32  to WB ReadDataW
- mem_fault  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - state = IDLE, timeout counter = 0, captured request registers = 0.
  - All registered outputs = 0; dmem_req = 0, stall = 0.
- FSM states: IDLE, BUSY.
- IDLE, no valid memory op (ex_valid = 0, or memread = memwrite = 0):
  - stall = 0.
  - Next edge loads the outputs from ex_* with read_data_m = 0. Latency 1.
  - ex_valid = 0 loads a bubble: regwrite_m = 0, rd_m = 0.
- IDLE, valid memory op, fault check fails:
  - Faults: illegal funct3 (load 011/110/111, store anything other than 000/001/010); misaligned address (H with addr[0] = 1, W with addr[1:0] ≠ 0).
  - No memory access, stall = 0.
  - Next edge: outputs loaded with regwrite_m forced to 0, mem_fault = 1 for one cycle.
- IDLE, valid memory op, no fault:
  - stall = 1.
  - Next edge: capture addr, we, wdata, wstrb, funct3 and the control fields; go to BUSY; load a bubble into the outputs.
- BUSY:
  - dmem_req = 1, with address, data and strobe driven from the captured registers and held stable.
  - stall = ~dmem_ready.
  - On dmem_ready = 1: next edge loads the outputs from the captured fields; read_data_m = formatted load data (0 for stores); go to IDLE. The EX instruction is consumed on this same edge.
  - Minimum memory-op latency is 2 cycles.
- Timeout: counter increments in each BUSY cycle without dmem_ready.
  - If TIMEOUT_CYCLES ≠ 0 and the count reaches TIMEOUT_CYCLES: stall = 0 that cycle, next edge loads outputs with regwrite_m = 0, mem_fault pulses, state returns to IDLE.
  - Counter clears on leaving BUSY.
- Store lane rules:
  - SB: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{half}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = store data, wstrb = 1111.
- Load extraction, lane selected by addr[1:0]:
  - LB: byte sign-extended. LBU: byte zero-extended.
  - LH: half sign-extended. LHU: half zero-extended.
  - LW: full word.
- dmem_ready outside BUSY is ignored.
- Asynchronous reset in BUSY drops dmem_req immediately; the in-flight access is discarded and no output is loaded.

Test Plan:
- ADD-type, ex_rd = 5, alu_result = 0x1234, regwrite = 1 → next cycle rd_m = 5, alu_result_m = 0x1234, regwrite_m = 1, stall never asserted.
- LB at 0x103, ready on first BUSY cycle, rdata = 0x80FF_0000 → dmem_addr = 0x100, read_data_m = 0xFFFF_FF80, memtoreg_m = 1, stall high for exactly 1 cycle.
- SH at 0x202, data 0xABCD → dmem_we = 1, wstrb = 1100, wdata = 0xABCD_ABCD, regwrite_m = 0.
- LW at 0x101 → no dmem_req, mem_fault pulses once, regwrite_m = 0, no stall.
- LHU at 0x10, ready delayed 3 cycles → dmem_req and dmem_addr stable across the wait, stall = 1 for 3 cycles then 0, rdata 0x0000_8001 → read_data_m = 0x0000_8001.
- TIMEOUT_CYCLES = 4, ready never asserted → abort after 4 BUSY cycles, mem_fault pulses, regwrite_m = 0. Second run: rst asserted mid-BUSY → dmem_req = 0 immediately, outputs 0.
